// File: rtl/rf_pkg.sv
// Shared register-file types and sizes.
// Used by the write-back unit and by the register file itself.
package rf_pkg;

  localparam int unsigned BITSIZE = 32;
  localparam int unsigned REGSIZE = 32;
  localparam int unsigned RIDX_W  = $clog2(REGSIZE);

  // One pending register-file write.
  typedef struct packed {
    logic [RIDX_W-1:0]  rd;
    logic [BITSIZE-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_unit_wb_fifo.sv
// wb_fifo: DEPTH-entry circular buffer of pending writes.
// Accepts 0, 1 or 2 pushes per edge (push_a is older than push_b) and at most
// one pop. Exposes the occupancy and an oldest-first view of all entries.
//  clk, rst          clock, synchronous active-high reset
//  push_a/data_a     first (older) push
//  push_b/data_b     second (younger) push
//  pop/head          remove the oldest entry / the oldest entry
//  count             number of occupied entries
//  view/view_valid   entries ordered oldest-first, with occupancy mask
module wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_a,
  input  wb_entry_t             data_a,
  input  logic                  push_b,
  input  wb_entry_t             data_b,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count,
  output wb_entry_t [DEPTH-1:0] view,
  output logic [DEPTH-1:0]      view_valid
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       n_push;

  assign n_push = {1'b0, push_a} + {1'b0, push_b};
  assign head   = mem[rd_ptr];

  // Storage; the younger push lands one slot after the older one.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= data_a;
    if (push_b) mem[wr_ptr + PTR_W'(push_a)] <= data_b;
  end

  // Pointers wrap modulo DEPTH; count tracks pushes minus pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  // Oldest-first view for the forwarding search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view[i]       = mem[rd_ptr + PTR_W'(i)];
      view_valid[i] = CNT_W'(i) < count;
    end
  end

endmodule

// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: write-side front end of the register file.
// Merges ALU and load results into an in-order buffer, drains one write per
// cycle onto the register-file write port and forwards pending values.
//  clk, rst                      clock, synchronous active-high reset
//  alu_valid/ready/rd/data       ALU result handshake
//  ld_valid/ready/rd/data        load result handshake
//  wb_en/wb_rd/wb_data           registered register-file write port
//  rs1_sel/fwd1_hit/fwd1_data    operand 1 forwarding lookup
//  rs2_sel/fwd2_hit/fwd2_data    operand 2 forwarding lookup
module rf_writeback_unit
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [RIDX_W-1:0]  alu_rd,
  input  logic [BITSIZE-1:0] alu_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [RIDX_W-1:0]  ld_rd,
  input  logic [BITSIZE-1:0] ld_data,
  output logic               wb_en,
  output logic [RIDX_W-1:0]  wb_rd,
  output logic [BITSIZE-1:0] wb_data,
  input  logic [RIDX_W-1:0]  rs1_sel,
  output logic               fwd1_hit,
  output logic [BITSIZE-1:0] fwd1_data,
  input  logic [RIDX_W-1:0]  rs2_sel,
  output logic               fwd2_hit,
  output logic [BITSIZE-1:0] fwd2_data
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      free;
  logic                  push_a;
  logic                  push_b;
  logic                  pop;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] view;
  logic [DEPTH-1:0]      view_valid;

  // Credit is taken from the pre-pop occupancy; the departing entry earns none.
  assign free      = CNT_W'(DEPTH) - count;
  assign alu_ready = free >= CNT_W'(1);
  assign ld_ready  = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !alu_valid);

  // Writes to x0 complete the handshake but never occupy a slot.
  assign push_a = alu_valid && alu_ready && (alu_rd != '0);
  assign push_b = ld_valid && ld_ready && (ld_rd != '0);
  assign pop    = count != '0;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_a    (push_a),
    .data_a    ('{rd: alu_rd, data: alu_data}),
    .push_b    (push_b),
    .data_b    ('{rd: ld_rd, data: ld_data}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .view      (view),
    .view_valid(view_valid)
  );

  // Register-file write port; rd/data hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= pop;
      if (pop) begin
        wb_rd   <= head.rd;
        wb_data <= head.data;
      end
    end
  end

  // Youngest match wins: the write register is oldest, then buffer entries
  // oldest-to-youngest, each later match overriding the earlier one.
  function automatic logic [BITSIZE:0] fwd_search(
    input logic [RIDX_W-1:0]   sel,
    input logic                en,
    input logic [RIDX_W-1:0]   rd,
    input logic [BITSIZE-1:0]  data,
    input wb_entry_t [DEPTH-1:0] ents,
    input logic [DEPTH-1:0]    vld
  );
    logic [BITSIZE:0] r;
    r = '0;
    if (sel != '0) begin
      if (en && (rd == sel)) r = {1'b1, data};
      for (int i = 0; i < DEPTH; i++) begin
        if (vld[i] && (ents[i].rd == sel)) r = {1'b1, ents[i].data};
      end
    end
    return r;
  endfunction

  assign {fwd1_hit, fwd1_data} = fwd_search(rs1_sel, wb_en, wb_rd, wb_data, view, view_valid);
  assign {fwd2_hit, fwd2_data} = fwd_search(rs2_sel, wb_en, wb_rd, wb_data, view, view_valid);

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Self-checking bench for rf_writeback_unit: scoreboard of accepted writes
// compared against the register-file write port, plus per-scenario checks.
module tb_rf_writeback_unit;
  import rf_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic               clk;
  logic               rst;
  logic               alu_valid, alu_ready, ld_valid, ld_ready;
  logic [RIDX_W-1:0]  alu_rd, ld_rd, wb_rd, rs1_sel, rs2_sel;
  logic [BITSIZE-1:0] alu_data, ld_data, wb_data, fwd1_data, fwd2_data;
  logic               wb_en, fwd1_hit, fwd2_hit;

  int        errors = 0;
  int        checks = 0;
  wb_entry_t exp_q[$];
  wb_entry_t mon_e;
  int        mcount = 0;
  logic      m_wb_en = 1'b0;
  logic      mon_en = 1'b0;
  logic      exp_alu_ready, exp_ld_ready, obs_alu_ready, obs_ld_ready;

  rf_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_sel(rs1_sel), .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .rs2_sel(rs2_sel), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write-port pulse must match the oldest accepted result.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (wb_en !== m_wb_en) begin
        errors++;
        $display("FAIL sb_wb_en t=%0t: got %b want %b", $time, wb_en, m_wb_en);
      end else if (wb_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_spurious: got rd=%0d data=%h want no write", wb_rd, wb_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({wb_rd, wb_data} !== mon_e) begin
            errors++;
            $display("FAIL sb_write: got rd=%0d data=%h want rd=%0d data=%h",
                     wb_rd, wb_data, mon_e.rd, mon_e.data);
          end
        end
      end
    end
  end

  // One clock of stimulus; models buffer occupancy and pushes expected writes.
  task automatic cycle(input logic av, input logic [RIDX_W-1:0] ard, input logic [BITSIZE-1:0] ad,
                       input logic lv, input logic [RIDX_W-1:0] lrd, input logic [BITSIZE-1:0] ldd);
    int   mfree;
    logic next_wb;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv;  ld_rd = lrd;  ld_data = ldd;
    #1;
    mfree = DEPTH - mcount;
    exp_alu_ready = mfree >= 1;
    exp_ld_ready  = (mfree >= 2) || (mfree == 1 && !av);
    obs_alu_ready = alu_ready;
    obs_ld_ready  = ld_ready;
    next_wb = mcount > 0;
    if (mcount > 0) mcount--;
    if (av && exp_alu_ready && ard != '0) begin exp_q.push_back('{rd: ard, data: ad}); mcount++; end
    if (lv && exp_ld_ready && lrd != '0) begin exp_q.push_back('{rd: lrd, data: ldd}); mcount++; end
    @(posedge clk);
    m_wb_en = next_wb;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      m_wb_en = 1'b0;
      #1;
    end
    exp_q.delete();
    mcount = 0;
    rst = 1'b0;
    alu_valid = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h1234_5678;
    ld_valid = 1'b1;  ld_rd = 5'd10;  ld_data = 32'h8765_4321;
    rs1_sel = 5'd9; rs2_sel = 5'd10;
    do_reset(2);
    mon_en = 1'b1;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
    checks++; if (wb_rd !== '0) begin errors++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
    checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd1_hit: got %b want 0", fwd1_hit); end
    checks++; if (fwd2_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd2_hit: got %b want 0", fwd2_hit); end
    repeat (3) idle();
    checks++; if (fwd1_hit !== 1'b0) begin errors++; $display("FAIL reset_leak_fwd: got %b want 0", fwd1_hit); end
  endtask

  task automatic test_single();
    rs1_sel = 5'd5; rs2_sel = 5'd6;
    cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
    checks++; if (obs_alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready: got %b want 1", obs_alu_ready); end
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL single_wb_early: got %b want 0", wb_en); end
    checks++; if ({fwd1_hit, fwd1_data} !== {1'b1, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL single_fwd_buf: got %b/%h want 1/deadbeef", fwd1_hit, fwd1_data); end
    checks++; if (fwd2_hit !== 1'b0) begin errors++; $display("FAIL single_fwd2_miss: got %b want 0", fwd2_hit); end
    idle();
    checks++; if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL single_wb: got %b/%0d/%h want 1/5/deadbeef", wb_en, wb_rd, wb_data); end
    checks++; if ({fwd1_hit, fwd1_data} !== {1'b1, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL single_fwd_wb: got %b/%h want 1/deadbeef", fwd1_hit, fwd1_data); end
    idle();
    checks++; if ({wb_en, wb_rd, wb_data} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL single_hold: got %b/%0d/%h want 0/5/deadbeef", wb_en, wb_rd, wb_data); end
    checks++; if ({fwd1_hit, fwd1_data} !== {1'b0, 32'h0}) begin errors++;
      $display("FAIL single_fwd_gone: got %b/%h want 0/0", fwd1_hit, fwd1_data); end
  endtask

  task automatic test_dual();
    rs1_sel = 5'd3; rs2_sel = 5'd3;
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    checks++; if (obs_ld_ready !== 1'b1) begin errors++; $display("FAIL dual_ld_ready: got %b want 1", obs_ld_ready); end
    checks++; if ({fwd1_hit, fwd1_data} !== {1'b1, 32'h22}) begin errors++;
      $display("FAIL dual_fwd_both: got %b/%h want 1/22", fwd1_hit, fwd1_data); end
    idle();
    checks++; if (wb_data !== 32'h11) begin errors++; $display("FAIL dual_first: got %h want 11", wb_data); end
    checks++; if ({fwd2_hit, fwd2_data} !== {1'b1, 32'h22}) begin errors++;
      $display("FAIL dual_fwd_one: got %b/%h want 1/22", fwd2_hit, fwd2_data); end
    idle();
    checks++; if (wb_data !== 32'h22) begin errors++; $display("FAIL dual_second: got %h want 22", wb_data); end
    checks++; if ({fwd1_hit, fwd1_data} !== {1'b1, 32'h22}) begin errors++;
      $display("FAIL dual_fwd_wb: got %b/%h want 1/22", fwd1_hit, fwd1_data); end
    idle();
  endtask

  task automatic test_x0();
    rs1_sel = 5'd0; rs2_sel = 5'd0;
    cycle(1'b1, 5'd0, 32'h0000_FFFF, 1'b1, 5'd0, 32'h0000_AAAA);
    checks++; if (obs_alu_ready !== 1'b1) begin errors++; $display("FAIL x0_alu_ready: got %b want 1", obs_alu_ready); end
    checks++; if ({fwd1_hit, fwd1_data} !== {1'b0, 32'h0}) begin errors++;
      $display("FAIL x0_fwd: got %b/%h want 0/0", fwd1_hit, fwd1_data); end
    idle();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL x0_wb_en: got %b want 0", wb_en); end
    // Occupancy untouched: with alu_valid high the load still sees two free slots.
    cycle(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2);
    checks++; if (obs_ld_ready !== exp_ld_ready) begin errors++;
      $display("FAIL x0_count: got ld_ready=%b want %b", obs_ld_ready, exp_ld_ready); end
    repeat (2) idle();
  endtask

  task automatic test_fill();
    int                 accepted = 0;
    int                 ld_block = 0;
    int                 guard = 0;
    logic               av, lv;
    logic [RIDX_W-1:0]  ard, lrd;
    logic [BITSIZE-1:0] add, ldd;
    lv = 1'b0; lrd = '0; ldd = '0;
    while (accepted < 100 && guard < 1000) begin
      av  = (guard < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ard = RIDX_W'($urandom_range(0, REGSIZE - 1));
      add = $urandom;
      if (!lv) begin
        lv  = 1'b1;
        lrd = RIDX_W'($urandom_range(0, REGSIZE - 1));
        ldd = $urandom;
      end
      cycle(av, ard, add, lv, lrd, ldd);
      checks++; if (obs_alu_ready !== exp_alu_ready) begin errors++;
        $display("FAIL fill_alu_ready cyc=%0d: got %b want %b", guard, obs_alu_ready, exp_alu_ready); end
      checks++; if (obs_ld_ready !== exp_ld_ready) begin errors++;
        $display("FAIL fill_ld_ready cyc=%0d: got %b want %b", guard, obs_ld_ready, exp_ld_ready); end
      if (av && !obs_ld_ready) ld_block++;
      if (av && exp_alu_ready) accepted++;
      if (exp_ld_ready) begin accepted++; lv = 1'b0; end
      guard++;
    end
    checks++; if (accepted < 100) begin errors++; $display("FAIL fill_timeout: got %0d results want 100", accepted); end
    checks++; if (ld_block == 0) begin errors++; $display("FAIL fill_ld_backpressure: got 0 stalls want >0"); end
    repeat (DEPTH + 2) idle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL fill_lost: got %0d unwritten want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    rs1_sel = 5'd13; rs2_sel = 5'd14;
    cycle(1'b1, 5'd11, 32'hA1, 1'b1, 5'd12, 32'hB2);
    cycle(1'b1, 5'd13, 32'hC3, 1'b1, 5'd14, 32'hD4);
    checks++; if (fwd1_hit !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", fwd1_hit); end
    alu_valid = 1'b0; ld_valid = 1'b0;
    do_reset(1);
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL mid_wb_en: got %b want 0", wb_en); end
    checks++; if ({fwd1_hit, fwd2_hit} !== 2'b00) begin errors++;
      $display("FAIL mid_fwd: got %b%b want 00", fwd1_hit, fwd2_hit); end
    rs1_sel = 5'd7;
    cycle(1'b1, 5'd7, 32'h7777_0007, 1'b1, 5'd8, 32'h8888_0008);
    checks++; if (obs_ld_ready !== 1'b1) begin errors++; $display("FAIL mid_count: got ld_ready=%b want 1", obs_ld_ready); end
    idle();
    checks++; if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd7, 32'h7777_0007}) begin errors++;
      $display("FAIL mid_post_write: got %b/%0d/%h want 1/7/77770007", wb_en, wb_rd, wb_data); end
    repeat (3) idle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_lost: got %0d unwritten want 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
    rs1_sel = '0; rs2_sel = '0;
    test_reset();
    test_single();
    test_dual();
    test_x0();
    test_fill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
